mixcol_byte_seq: RTL and testbench
==================================

Name: mixcol_byte_seq

Overview:
- Byte-serial sequencer that lets the 8-bit AES datapath use the existing single-column MixColumns unit.
- Collects 4 state bytes per column, transforms them in one shot, and streams the 4 result bytes back out.
- Processes one 16-byte state per block (4 columns) with valid/ready handshakes on both sides.
- Sits between the ShiftRows byte stream and AddRoundKey in the round pipeline; a per-block bypass serves the final round, which has no MixColumns.

Parameters:
- BLK_COLS, 4, columns per AES state; fixed at 4 and checked by an elaboration assertion.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of all buffers and counters
- bypass  in  1  block skips MixColumns; sampled on the block's first input byte
- in_valid  in  1  input byte valid
- in_ready  out  1  sequencer can accept a byte
- in_data  in  8  input byte; byte k of a column is s_k, column 0 first
- out_valid  out  1  output byte valid
- out_ready  in  1  downstream accepts the byte
- out_data  out  8  output byte o_k, same ordering as input
- out_last  out  1  high with the 16th byte of a block
- busy  out  1  any byte held or block in progress

Behaviour:
- Reset (async, rst_n=0): all outputs 0, including in_ready (it rises on the first clk edge after release). All counters and buffers clear; bypass_q clears to 0.
- Input handshake: a byte is accepted when in_valid & in_ready.
  - It is written to collector slot in_cnt[1:0]; in_cnt increments.
  - Slot 3 sets coll_full.
- xfer (combinational) = coll_full & (out_cnt==0 | (out_cnt==1 & out_ready)).
- in_ready = !coll_full | xfer.
  - Full rate: one byte/cycle is sustained when out_ready stays high.
- On xfer, the 4 output bytes load into the output shifter and out_cnt becomes 4; coll_full clears.
  - Loaded value is the MixColumns result {o0..o3} of the collector, or the raw collector when bypass_q=1.
  - If the same cycle also accepts a byte, that byte goes to slot 0 and in_cnt becomes 1.
- Output: out_valid = (out_cnt!=0); out_data = current head byte.
  - Each out_valid & out_ready shifts the shifter and decrements out_cnt.
  - out_data and out_valid stay stable while out_ready=0.
- Latency: 4th byte of a column accepted at edge N → out_valid=1 with o0 after edge N+1 (xfer edge), provided the shifter is empty or draining its last byte.
- Column/block tracking:
  - col_in (2b) increments on each xfer and wraps 3→0.
  - out_col (2b) and out_byte (2b) track output position.
  - out_last = out_valid & out_col==3 & out_byte==3.
- bypass_q captures bypass when a byte is accepted with in_cnt==0 & col_in==0, and holds for all 4 columns of that block.
  - A change on bypass mid-block is ignored.
  - The next block may carry a different bypass while the previous block's tail is still draining, because the mode is carried per column (see the bypass bit below).
- Each shifter entry stores a bypass bit for debug. Only the xfer-time value matters.
- busy = coll_full | in_cnt!=0 | out_cnt!=0 | col_in!=0 | out_col!=0.
- Arithmetic: GF(2^8) mod x^8+x^4+x^3+x+1, provided entirely by the sub-module; no other arithmetic.
- flush: next edge equals reset state except in_ready=1. Held bytes are discarded without emission. flush takes priority over simultaneous accept/xfer/shift.
- Reset or flush mid-block: the partial column is dropped and the next accepted byte is s0 of column 0 of a new block.
- Stalls:
  - Back-pressure with out_ready=0: at most 4 bytes wait in the collector, then in_ready=0.
  - No byte is ever lost or duplicated.

Decomposition:
- Package aes_pkg holds:
  - AES_COL_BYTES=4 and AES_STATE_BYTES=16
  - byte_t (logic[7:0]) and col_t (byte_t[3:0])
  - AES_POLY=8'h1B
- One sub-module: the existing single-column unit mixcolumn, instantiated once on the collector output.
- Counters and the shifter stay inline.

Test Plan:
- Single column, bypass=0: stream db,13,53,45 with out_ready=1 → out 8e,4d,a1,bc, out_valid first seen one edge after the 4th accept.
- Full block, bypass=0: columns {db135345},{f20a225c},{01010101},{c6c6c6c6} at 1 byte/cycle → out 8e4da1bc, 9fdc589d, 01010101, c6c6c6c6. in_ready is never low, and out_last is set only on the 16th byte (c6).
- Bypass block: bypass=1 on byte 0 and 0 afterwards, same 16 bytes → output equals input. The following block sent with bypass=0 is mixed.
- Back-pressure: out_ready=0 for 10 cycles during column 1 → in_ready drops after 4 collector bytes, out_data holds 9f stable, and the full sequence completes without loss or duplication once out_ready=1.
- flush after 6 bytes in (mid-column 1) → busy=0 next cycle with no stray out_valid. A fresh block db,13,53,45… then yields 8e,4d,a1,bc with correct out_last.
- Async reset asserted mid-emission (out_cnt=2) → out_valid and in_ready are 0 immediately. After release, a new column produces correct results.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES byte/column types and field constants for the byte-serial round datapath.
package aes_pkg;

    localparam int unsigned AES_COL_BYTES   = 4;
    localparam int unsigned AES_STATE_BYTES = 16;
    localparam logic [7:0]  AES_POLY        = 8'h1B;

    typedef logic [7:0] byte_t;
    // Element k holds state byte s_k of the column.
    typedef byte_t [3:0] col_t;

endpackage

// File: rtl/mixcolumn.sv
// Single-column AES MixColumns: o_k = 2*s_k ^ 3*s_(k+1) ^ s_(k+2) ^ s_(k+3) over GF(2^8).
module mixcolumn
    import aes_pkg::*;
(
    input  col_t state_col,
    output col_t mixed_col
);

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    always_comb begin
        mixed_col = '0;
        for (int k = 0; k < 4; k++) begin
            mixed_col[2'(k)] = xtime(state_col[2'(k)])
                             ^ xtime(state_col[2'(k + 1)]) ^ state_col[2'(k + 1)]
                             ^ state_col[2'(k + 2)]
                             ^ state_col[2'(k + 3)];
        end
    end

endmodule

// File: rtl/mixcol_byte_seq.sv
// Byte-serial wrapper around the single-column MixColumns unit: gathers 4 bytes,
// transforms them in one shot and streams the result bytes back out.
module mixcol_byte_seq
    import aes_pkg::*;
#(
    parameter int unsigned BLK_COLS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       bypass,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       busy
);

    if (BLK_COLS != 4) begin : g_bad_cols
        $error("mixcol_byte_seq: BLK_COLS must be 4");
    end

    logic       en_q;
    col_t       coll_q;
    logic [1:0] in_cnt_q;
    logic       coll_full_q;
    logic [2:0] out_cnt_q;
    col_t       shf_q;
    logic [3:0] shf_byp_q;
    logic [1:0] col_in_q;
    logic [1:0] out_col_q;
    logic [1:0] out_byte_q;
    logic       bypass_q;

    col_t mixed;
    logic xfer;
    logic accept;
    logic shift;
    logic blk_start;

    mixcolumn u_mixcolumn (
        .state_col (coll_q),
        .mixed_col (mixed)
    );

    assign xfer      = coll_full_q & ((out_cnt_q == 3'd0) | ((out_cnt_q == 3'd1) & out_ready));
    assign in_ready  = en_q & (~coll_full_q | xfer);
    assign accept    = in_valid & in_ready;
    assign out_valid = (out_cnt_q != 3'd0);
    assign shift     = out_valid & out_ready;
    assign out_data  = shf_q[0];
    assign out_last  = out_valid & (out_col_q == 2'd3) & (out_byte_q == 2'd3);
    assign busy      = coll_full_q | (in_cnt_q != 2'd0) | (out_cnt_q != 3'd0) |
                       (col_in_q != 2'd0) | (out_col_q != 2'd0);

    // A full collector means the next byte belongs to the following column, so a block
    // boundary can coincide with the xfer of the previous block's last column.
    assign blk_start = accept & (in_cnt_q == 2'd0) &
                       (coll_full_q ? (col_in_q == 2'd3) : (col_in_q == 2'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q        <= 1'b0;
            coll_q      <= '0;
            in_cnt_q    <= 2'd0;
            coll_full_q <= 1'b0;
            out_cnt_q   <= 3'd0;
            shf_q       <= '0;
            shf_byp_q   <= 4'd0;
            col_in_q    <= 2'd0;
            out_col_q   <= 2'd0;
            out_byte_q  <= 2'd0;
            bypass_q    <= 1'b0;
        end else if (flush) begin
            en_q        <= 1'b1;
            coll_q      <= '0;
            in_cnt_q    <= 2'd0;
            coll_full_q <= 1'b0;
            out_cnt_q   <= 3'd0;
            shf_q       <= '0;
            shf_byp_q   <= 4'd0;
            col_in_q    <= 2'd0;
            out_col_q   <= 2'd0;
            out_byte_q  <= 2'd0;
            bypass_q    <= 1'b0;
        end else begin
            en_q <= 1'b1;
            if (xfer) begin
                shf_q       <= bypass_q ? coll_q : mixed;
                shf_byp_q   <= {4{bypass_q}};
                out_cnt_q   <= 3'(AES_COL_BYTES);
                coll_full_q <= 1'b0;
                col_in_q    <= col_in_q + 2'd1;
            end else if (shift) begin
                shf_q     <= col_t'(shf_q >> 8);
                shf_byp_q <= shf_byp_q >> 1;
                out_cnt_q <= out_cnt_q - 3'd1;
            end
            if (shift) begin
                out_byte_q <= out_byte_q + 2'd1;
                if (out_byte_q == 2'd3) begin
                    out_col_q <= out_col_q + 2'd1;
                end
            end
            if (accept) begin
                coll_q[in_cnt_q] <= in_data;
                in_cnt_q         <= in_cnt_q + 2'd1;
                if (in_cnt_q == 2'd3) begin
                    coll_full_q <= 1'b1;
                end
                if (blk_start) begin
                    bypass_q <= bypass;
                end
            end
        end
    end

endmodule

// File: tb/tb_mixcol_byte_seq.sv
// Randomised self-checking bench for mixcol_byte_seq with a GF(2^8) matrix reference model.
module tb_mixcol_byte_seq;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       bypass;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    mixcol_byte_seq #(
        .BLK_COLS (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bypass    (bypass),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    localparam logic [7:0] BLK_A [16] = '{
        8'hdb, 8'h13, 8'h53, 8'h45, 8'hf2, 8'h0a, 8'h22, 8'h5c,
        8'h01, 8'h01, 8'h01, 8'h01, 8'hc6, 8'hc6, 8'hc6, 8'hc6
    };

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks;
    int         n_errors;
    int         stall_cnt;
    int         blk_pos;
    logic       m_byp;
    logic [7:0] m_col [4];
    logic       rand_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Carry-less product followed by long division by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ (16'(a) << i);
        end
        for (int i = 15; i >= 8; i--) begin
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        end
        return p[7:0];
    endfunction

    task automatic model_accept(input logic [7:0] b, input logic byp);
        int   coef [4];
        exp_t e;
        coef = '{2, 3, 1, 1};
        if (blk_pos == 0) m_byp = byp;
        m_col[blk_pos % 4] = b;
        if (blk_pos % 4 == 3) begin
            for (int i = 0; i < 4; i++) begin
                if (m_byp) begin
                    e.d = m_col[i];
                end else begin
                    e.d = 8'h00;
                    for (int j = 0; j < 4; j++) begin
                        e.d = e.d ^ gf_mul(8'(coef[(j - i + 4) % 4]), m_col[j]);
                    end
                end
                e.l = (blk_pos == 15) && (i == 3);
                exp_q.push_back(e);
            end
        end
        blk_pos = (blk_pos + 1) % 16;
    endtask

    always @(negedge clk) begin
        if (!rst_n || flush) begin
            exp_q.delete();
            blk_pos = 0;
        end else begin
            if (in_valid && in_ready) model_accept(in_data, bypass);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_out", 32'(out_data), 32'h100);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("out_data", 32'(out_data), 32'(e.d));
                    check_eq("out_last", 32'(out_last), 32'(e.l));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push_byte(input logic [7:0] b, input logic byp);
        int   n;
        logic acc;
        n        = 0;
        in_valid = 1'b1;
        in_data  = b;
        bypass   = byp;
        do begin
            @(negedge clk);
            acc = in_ready;
            if (!acc) stall_cnt++;
            step();
            n++;
        end while (!acc && n < 200);
        if (!acc) check_eq("push_timeout", 32'(n), 32'd0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 1000) begin
            step();
            n++;
        end
        check_eq("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired @%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        stall_cnt  = 0;
        rand_ready = 1'b0;
        rst_n      = 1'b0;
        flush      = 1'b0;
        bypass     = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        out_ready  = 1'b0;

        #12;
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_last", 32'(out_last), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1 check_eq("rel_in_ready_low", 32'(in_ready), 32'd0);
        step();
        check_eq("rel_in_ready_high", 32'(in_ready), 32'd1);
        out_ready = 1'b1;

        // Single column and its latency.
        for (int i = 0; i < 4; i++) push_byte(BLK_A[i], 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("lat_early", 32'(out_valid), 32'd0);
        step();
        check_eq("lat_valid", 32'(out_valid), 32'd1);
        check_eq("lat_o0", 32'(out_data), 32'h8e);
        wait_drain();
        flush = 1'b1;
        step();
        flush = 1'b0;

        // Full block at one byte per cycle.
        stall_cnt = 0;
        for (int i = 0; i < 16; i++) push_byte(BLK_A[i], 1'b0);
        in_valid = 1'b0;
        check_eq("full_rate_stalls", 32'(stall_cnt), 32'd0);
        wait_drain();
        check_eq("full_busy_idle", 32'(busy), 32'd0);

        // Bypass block, then a mixed block right behind it.
        for (int i = 0; i < 16; i++) push_byte(BLK_A[i], (i == 0));
        for (int i = 0; i < 16; i++) push_byte(BLK_A[i], 1'b0);
        in_valid = 1'b0;
        wait_drain();

        // Back-pressure while column 1 sits in the shifter.
        for (int i = 0; i < 8; i++) push_byte(BLK_A[i], 1'b0);
        fork
            begin
                for (int i = 8; i < 16; i++) push_byte(BLK_A[i], 1'b0);
                in_valid = 1'b0;
            end
            begin
                step();
                out_ready = 1'b0;
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    check_eq("bp_valid", 32'(out_valid), 32'd1);
                    check_eq("bp_hold", 32'(out_data), 32'h9f);
                    step();
                end
                @(negedge clk);
                check_eq("bp_in_ready", 32'(in_ready), 32'd0);
                step();
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Flush in the middle of column 1.
        for (int i = 0; i < 6; i++) push_byte(BLK_A[i], 1'b0);
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        check_eq("flush_busy", 32'(busy), 32'd0);
        check_eq("flush_valid", 32'(out_valid), 32'd0);
        step();
        check_eq("flush_valid_2", 32'(out_valid), 32'd0);
        for (int i = 0; i < 16; i++) push_byte(BLK_A[i], 1'b0);
        in_valid = 1'b0;
        wait_drain();

        // Async reset with two bytes still in the shifter.
        for (int i = 0; i < 4; i++) push_byte(BLK_A[i], 1'b0);
        in_valid = 1'b0;
        step();
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 32'(out_valid), 32'd0);
        check_eq("arst_in_ready", 32'(in_ready), 32'd0);
        #12;
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        check_eq("arst_rel_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 16; i++) push_byte(BLK_A[i], 1'b0);
        in_valid = 1'b0;
        wait_drain();

        // Random blocks, random bypass, random gaps and random out_ready.
        rand_ready = 1'b1;
        for (int b = 0; b < 12; b++) begin
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    repeat ($urandom_range(1, 3)) step();
                end
                push_byte(8'($urandom), 1'($urandom_range(0, 1)));
            end
        end
        in_valid = 1'b0;
        wait_drain();
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        step();
        check_eq("rand_busy_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
